// File: rtl/sa_params_pkg.sv
// Shared parameters and types for the SA segment buffers.
//   AXI_DATA_WIDTH : default word width of the loader/engine data path
//   MBUF_MAX_BANKS : upper bound on the ring bank count
//   bank_state_e   : per-bank life cycle EMPTY -> FILL -> FULL -> ACTIVE -> EMPTY
//   seg_len_clamp  : maps a requested segment length onto 1..depth (0 or oversize -> depth)
package sa_params_pkg;

  localparam int AXI_DATA_WIDTH = 32;
  localparam int MBUF_MAX_BANKS = 16;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    FILL   = 2'd1,
    FULL   = 2'd2,
    ACTIVE = 2'd3
  } bank_state_e;

  function automatic int unsigned seg_len_clamp(input logic [31:0] words, input int unsigned depth);
    return (words == 32'd0 || words > depth) ? depth : words;
  endfunction

endpackage

// File: rtl/sa_sdp_ram.sv
// Inferred simple dual-port RAM, one bank of the segment ring.
//   clk          : clock
//   we/waddr/wdata : port A write
//   re/raddr     : port B read enable / address
//   rdata        : port B data, registered (1 cycle after re), held when re=0
// No reset on the array or the output register so it maps onto block RAM.
module sa_sdp_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/bram_multibank_ring.sv
// N-bank segment ring between the DMA/AXI loader (producer) and the SA engine (consumer).
// Banks are filled and drained strictly round-robin; each bank keeps its own segment length.
// Ports:
//   clk, rstn (sync, active low), flush (clears ring state, lets the read pipe drain)
//   fill side   : seg_words, fill_req, fill_busy, fill_we, fill_addr, fill_wdata, fill_done
//   consume side: consume_req, consume_busy, rd_en, rd_addr, rd_rdata, rd_valid, cons_commit, consume_done
//   status      : fill_bank_idx, cons_bank_idx, full_cnt, fill_stall_cnt, cons_stall_cnt
// Build option: define SA_MBUF_STATS_EN to build the saturating stall counters;
// without it both counters are tied to 0.
module bram_multibank_ring
  import sa_params_pkg::*;
#(
  parameter int DATA_W          = AXI_DATA_WIDTH,
  parameter int DEPTH           = 64,
  parameter int ADDR_W          = $clog2(DEPTH),
  parameter int NUM_BANKS       = 4,
  parameter int RD_LAT          = 1,
  parameter bit USE_CONS_COMMIT = 1'b1,
  localparam int BI_W           = $clog2(NUM_BANKS),
  localparam int FC_W           = $clog2(NUM_BANKS + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic [31:0]       seg_words,
  input  logic              fill_req,
  output logic              fill_busy,
  input  logic              fill_we,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [DATA_W-1:0] fill_wdata,
  output logic              fill_done,
  input  logic              consume_req,
  output logic              consume_busy,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_rdata,
  output logic              rd_valid,
  input  logic              cons_commit,
  output logic              consume_done,
  output logic [BI_W-1:0]   fill_bank_idx,
  output logic [BI_W-1:0]   cons_bank_idx,
  output logic [FC_W-1:0]   full_cnt,
  output logic [31:0]       fill_stall_cnt,
  output logic [31:0]       cons_stall_cnt
);

  localparam int LEN_W = $clog2(DEPTH + 1);

  bank_state_e                   bank_st [NUM_BANKS];
  logic [LEN_W-1:0]              seg_len [NUM_BANKS];
  logic [BI_W-1:0]               fill_ptr, cons_ptr;
  logic [LEN_W-1:0]              fill_cnt, cons_cnt;
  logic                          fill_pend_q, cons_pend_q;
  logic [NUM_BANKS-1:0][DATA_W-1:0] ram_q;

  function automatic logic [BI_W-1:0] ptr_inc(input logic [BI_W-1:0] p);
    return (p == BI_W'(NUM_BANKS - 1)) ? '0 : p + 1'b1;
  endfunction

  // A request counts in the cycle it arrives as well as while it is held.
  logic fill_pend, cons_pend, fill_grant, cons_grant, fill_wr, cons_rd, fill_last, cons_last;
  assign fill_pend  = fill_pend_q | fill_req;
  assign cons_pend  = cons_pend_q | consume_req;
  assign fill_grant = fill_pend & ~fill_busy & (bank_st[fill_ptr] == EMPTY);
  assign cons_grant = cons_pend & ~consume_busy & (bank_st[cons_ptr] == FULL);
  assign fill_wr    = fill_busy & fill_we;
  assign cons_rd    = consume_busy & rd_en;
  assign fill_last  = fill_wr & ((fill_cnt + LEN_W'(1)) == seg_len[fill_ptr]);
  assign cons_last  = USE_CONS_COMMIT ? (consume_busy & cons_commit)
                                      : (cons_rd & ((cons_cnt + LEN_W'(1)) == seg_len[cons_ptr]));

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_st[b] <= EMPTY;
        seg_len[b] <= '0;
      end
      fill_ptr     <= '0;
      cons_ptr     <= '0;
      fill_cnt     <= '0;
      cons_cnt     <= '0;
      fill_pend_q  <= 1'b0;
      cons_pend_q  <= 1'b0;
      fill_busy    <= 1'b0;
      consume_busy <= 1'b0;
      fill_done    <= 1'b0;
      consume_done <= 1'b0;
    end else begin
      fill_pend_q  <= fill_pend & ~fill_grant;
      cons_pend_q  <= cons_pend & ~cons_grant;
      fill_done    <= 1'b0;
      consume_done <= 1'b0;
      if (fill_grant) begin
        bank_st[fill_ptr] <= FILL;
        seg_len[fill_ptr] <= LEN_W'(seg_len_clamp(seg_words, DEPTH));
        fill_busy         <= 1'b1;
        fill_cnt          <= '0;
      end
      if (fill_wr) fill_cnt <= fill_cnt + LEN_W'(1);
      if (fill_last) begin
        bank_st[fill_ptr] <= FULL;
        fill_done         <= 1'b1;
        fill_busy         <= 1'b0;
        fill_ptr          <= ptr_inc(fill_ptr);
      end
      if (cons_grant) begin
        bank_st[cons_ptr] <= ACTIVE;
        consume_busy      <= 1'b1;
        cons_cnt          <= '0;
      end
      if (cons_rd) cons_cnt <= cons_cnt + LEN_W'(1);
      if (cons_last) begin
        bank_st[cons_ptr] <= EMPTY;
        consume_done      <= 1'b1;
        consume_busy      <= 1'b0;
        cons_ptr          <= ptr_inc(cons_ptr);
      end
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    sa_sdp_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
      .clk   (clk),
      .we    (fill_wr && fill_ptr == BI_W'(g)),
      .waddr (fill_addr),
      .wdata (fill_wdata),
      .re    (cons_rd && cons_ptr == BI_W'(g)),
      .raddr (rd_addr),
      .rdata (ram_q[g])
    );
  end

  // The bank select travels with the read: on the segment's last read cons_ptr
  // advances in the same edge the RAM captures the word.
  logic            rd_act_q, rd_en_q;
  logic [BI_W-1:0] rd_bank_q;
  logic [DATA_W-1:0] rd_d1;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_act_q  <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_bank_q <= '0;
    end else begin
      rd_act_q  <= cons_rd;
      rd_en_q   <= rd_en;
      rd_bank_q <= cons_ptr;
    end
  end

  assign rd_d1 = rd_act_q ? ram_q[rd_bank_q] : '0;

  if (RD_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] rdata_q;
    logic              vld_q;
    always_ff @(posedge clk) begin
      if (!rstn) begin
        rdata_q <= '0;
        vld_q   <= 1'b0;
      end else begin
        rdata_q <= rd_d1;
        vld_q   <= rd_en_q;
      end
    end
    assign rd_rdata = rdata_q;
    assign rd_valid = vld_q;
  end else begin : g_lat1
    assign rd_rdata = rd_d1;
    assign rd_valid = rd_en_q;
  end

  always_comb begin
    full_cnt = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      if (bank_st[b] == FULL) full_cnt = full_cnt + FC_W'(1);
  end

  assign fill_bank_idx = fill_ptr;
  assign cons_bank_idx = cons_ptr;

`ifdef SA_MBUF_STATS_EN
  // In a strict ring the pointed-to bank being busy means the whole ring is
  // blocked for that side, so only that bank needs checking.
  logic [31:0] fill_stall_q, cons_stall_q;
  logic        fill_blk, cons_blk;
  assign fill_blk = fill_pend & ~fill_busy & (bank_st[fill_ptr] != EMPTY);
  assign cons_blk = cons_pend & ~consume_busy & (bank_st[cons_ptr] != FULL);

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      fill_stall_q <= '0;
      cons_stall_q <= '0;
    end else begin
      if (fill_blk && fill_stall_q != '1) fill_stall_q <= fill_stall_q + 32'd1;
      if (cons_blk && cons_stall_q != '1) cons_stall_q <= cons_stall_q + 32'd1;
    end
  end

  assign fill_stall_cnt = fill_stall_q;
  assign cons_stall_cnt = cons_stall_q;
`else
  assign fill_stall_cnt = '0;
  assign cons_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_bram_multibank_ring.sv
// Bench for bram_multibank_ring. Two instances share all inputs:
//   dut 0: USE_CONS_COMMIT=1, RD_LAT=1 (segment closed by cons_commit)
//   dut 1: USE_CONS_COMMIT=0, RD_LAT=2 (segment closed by its last counted read)
// A reference model (bank memory image, segment length queue, ring counters)
// predicts read data and its arrival cycle; a monitor pops and compares on rd_valid.
module tb_bram_multibank_ring;

  localparam int DW = 32, DEPTH = 64, AW = 6, NB = 4, BW = 2, FW = 3;

  logic clk = 1'b0, rstn = 1'b0, flush = 1'b0;
  logic fill_req = 1'b0, fill_we = 1'b0, consume_req = 1'b0, rd_en = 1'b0, cons_commit = 1'b0;
  logic [31:0] seg_words = '0;
  logic [AW-1:0] fill_addr = '0, rd_addr = '0;
  logic [DW-1:0] fill_wdata = '0;

  logic          fill_busy [2], fill_done [2], consume_busy [2], consume_done [2], rd_valid [2];
  logic [DW-1:0] rd_rdata [2];
  logic [BW-1:0] fbi [2], cbi [2];
  logic [FW-1:0] full_cnt [2];
  logic [31:0]   fsc [2], csc [2];

  bram_multibank_ring #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_BANKS(NB), .RD_LAT(1), .USE_CONS_COMMIT(1'b1)) u_dut_c (
    .clk(clk), .rstn(rstn), .flush(flush), .seg_words(seg_words),
    .fill_req(fill_req), .fill_busy(fill_busy[0]), .fill_we(fill_we), .fill_addr(fill_addr),
    .fill_wdata(fill_wdata), .fill_done(fill_done[0]),
    .consume_req(consume_req), .consume_busy(consume_busy[0]), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_rdata(rd_rdata[0]), .rd_valid(rd_valid[0]), .cons_commit(cons_commit), .consume_done(consume_done[0]),
    .fill_bank_idx(fbi[0]), .cons_bank_idx(cbi[0]), .full_cnt(full_cnt[0]),
    .fill_stall_cnt(fsc[0]), .cons_stall_cnt(csc[0]));

  bram_multibank_ring #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_BANKS(NB), .RD_LAT(2), .USE_CONS_COMMIT(1'b0)) u_dut_r (
    .clk(clk), .rstn(rstn), .flush(flush), .seg_words(seg_words),
    .fill_req(fill_req), .fill_busy(fill_busy[1]), .fill_we(fill_we), .fill_addr(fill_addr),
    .fill_wdata(fill_wdata), .fill_done(fill_done[1]),
    .consume_req(consume_req), .consume_busy(consume_busy[1]), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_rdata(rd_rdata[1]), .rd_valid(rd_valid[1]), .cons_commit(cons_commit), .consume_done(consume_done[1]),
    .fill_bank_idx(fbi[1]), .cons_bank_idx(cbi[1]), .full_cnt(full_cnt[1]),
    .fill_stall_cnt(fsc[1]), .cons_stall_cnt(csc[1]));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h (cycle %0d)", nm, d, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] mem [NB][DEPTH];
  int lens [$];
  int fill_n = 0, cons_n = 0;

  typedef struct { int cyc; logic [DW-1:0] data; } rd_exp_t;
  rd_exp_t q0 [$], q1 [$];
  rd_exp_t e0, e1;

  function automatic int eff_len(input logic [31:0] w);
    return (w == 32'd0 || w > 32'(DEPTH)) ? DEPTH : int'(w);
  endfunction

  task automatic model_clear();
    fill_n = 0;
    cons_n = 0;
    lens.delete();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rstn && rd_valid[0]) begin
      if (q0.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rd_unexpected dut0: got rd_valid=1 expected no read in flight (cycle %0d)", cyc);
      end else begin
        e0 = q0.pop_front();
        chk("rd_cycle", 0, 32'(cyc), 32'(e0.cyc));
        chk("rd_data", 0, rd_rdata[0], e0.data);
      end
    end
    if (rstn && rd_valid[1]) begin
      if (q1.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rd_unexpected dut1: got rd_valid=1 expected no read in flight (cycle %0d)", cyc);
      end else begin
        e1 = q1.pop_front();
        chk("rd_cycle", 1, 32'(cyc), 32'(e1.cyc));
        chk("rd_data", 1, rd_rdata[1], e1.data);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic busy_of(input int which, input int d);
    return (which == 0) ? fill_busy[d] : consume_busy[d];
  endfunction

  task automatic wait_both(input int which, input string nm);
    int n = 0;
    while (!(busy_of(which, 0) && busy_of(which, 1)) && n < 300) begin
      tick();
      n++;
    end
    n_chk++;
    if (n >= 300) begin
      n_fail++;
      $display("FAIL %s: got no grant within 300 cycles expected busy on both duts", nm);
    end
  endtask

  task automatic chk_idle(input string nm);
    for (int d = 0; d < 2; d++) begin
      chk({nm, "_fill_busy"}, d, 32'(fill_busy[d]), 0);
      chk({nm, "_cons_busy"}, d, 32'(consume_busy[d]), 0);
      chk({nm, "_fill_done"}, d, 32'(fill_done[d]), 0);
      chk({nm, "_cons_done"}, d, 32'(consume_done[d]), 0);
      chk({nm, "_fill_idx"}, d, 32'(fbi[d]), 0);
      chk({nm, "_cons_idx"}, d, 32'(cbi[d]), 0);
      chk({nm, "_full_cnt"}, d, 32'(full_cnt[d]), 0);
      chk({nm, "_rd_valid"}, d, 32'(rd_valid[d]), 0);
      chk({nm, "_rd_rdata"}, d, rd_rdata[d], 0);
      chk({nm, "_fill_stall"}, d, fsc[d], 0);
      chk({nm, "_cons_stall"}, d, csc[d], 0);
    end
  endtask

  // Fill one segment; stop_at >= 0 abandons it after that many words.
  task automatic do_fill(input logic [31:0] w, input bit req, input int stop_at);
    int b;
    int len;
    b   = fill_n % NB;
    len = eff_len(w);
    if (req) begin
      seg_words = w;
      fill_req  = 1'b1;
      tick();
      fill_req  = 1'b0;
    end
    wait_both(0, "fill_grant");
    seg_words = $urandom;  // length is latched at grant; later changes must not matter
    for (int d = 0; d < 2; d++) chk("fill_idx", d, 32'(fbi[d]), 32'(b));
    for (int i = 0; i < len; i++) begin
      if (i == stop_at) return;
      fill_we    = 1'b1;
      fill_addr  = AW'(i);
      fill_wdata = $urandom;
      mem[b][i]  = fill_wdata;
      tick();
      fill_we    = 1'b0;
      for (int d = 0; d < 2; d++) chk("fill_done_at_len", d, 32'(fill_done[d]), 32'(i == len - 1));
    end
    fill_n++;
    lens.push_back(len);
  endtask

  // Consume one segment: len reads, then a commit pulse (closes dut 0, ignored by dut 1).
  task automatic do_consume(input bit req, input int stop_after);
    int b;
    int len;
    int a;
    b   = cons_n % NB;
    len = lens[0];
    if (req) begin
      consume_req = 1'b1;
      tick();
      consume_req = 1'b0;
    end
    wait_both(1, "cons_grant");
    for (int d = 0; d < 2; d++) chk("cons_idx", d, 32'(cbi[d]), 32'(b));
    for (int i = 0; i < len; i++) begin
      if (i == stop_after) return;
      a       = (i == 0) ? 0 : int'($urandom_range(0, len - 1));
      rd_en   = 1'b1;
      rd_addr = AW'(a);
      q0.push_back(rd_exp_t'{cyc + 1, mem[b][a]});
      q1.push_back(rd_exp_t'{cyc + 2, mem[b][a]});
      tick();
      rd_en   = 1'b0;
      chk("cons_done_commit_mode", 0, 32'(consume_done[0]), 0);
      chk("cons_done_at_len", 1, 32'(consume_done[1]), 32'(i == len - 1));
    end
    cons_commit = 1'b1;
    tick();
    cons_commit = 1'b0;
    chk("cons_done_on_commit", 0, 32'(consume_done[0]), 1);
    chk("cons_done_commit_ignored", 1, 32'(consume_done[1]), 0);
    for (int d = 0; d < 2; d++) chk("cons_busy_after", d, 32'(consume_busy[d]), 0);
    void'(lens.pop_front());
    cons_n++;
  endtask

  task automatic chk_stall(input string nm, input int d, input logic [31:0] v);
`ifdef SA_MBUF_STATS_EN
    chk(nm, d, 32'(v != 0), 1);
`else
    chk(nm, d, v, 0);
`endif
  endtask

  // ---------------- test sequence ----------------
  initial begin
    repeat (3) tick();
    chk_idle("reset");
    rstn = 1'b1;
    tick();

    // Fill the whole ring with default-length segments, then block a fifth request.
    for (int s = 0; s < NB; s++) do_fill(32'd0, 1'b1, -1);
    for (int d = 0; d < 2; d++) chk("ring_full_cnt", d, 32'(full_cnt[d]), NB);
    seg_words = 32'd5;
    fill_req  = 1'b1;
    tick();
    fill_req  = 1'b0;
    // Writes with no open segment must be dropped (bank 0 addr 0..3 are read back later).
    for (int i = 0; i < 4; i++) begin
      fill_we    = 1'b1;
      fill_addr  = AW'(i);
      fill_wdata = ~mem[0][i];
      tick();
    end
    fill_we = 1'b0;
    repeat (6) tick();
    for (int d = 0; d < 2; d++) begin
      chk("pending_fill_busy", d, 32'(fill_busy[d]), 0);
      chk("pending_fill_idx", d, 32'(fbi[d]), 0);
      chk_stall("fill_stall", d, fsc[d]);
    end

    // Draining bank 0 releases the held fill one cycle after consume_done.
    do_consume(1'b1, -1);
    chk("held_fill_not_yet", 0, 32'(fill_busy[0]), 0);
    chk("held_fill_granted", 1, 32'(fill_busy[1]), 1);
    tick();
    chk("held_fill_granted", 0, 32'(fill_busy[0]), 1);
    do_fill(32'd5, 1'b0, -1);
    for (int s = 0; s < NB; s++) do_consume(1'b1, -1);

    // Idle flush returns pointers to bank 0.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    model_clear();
    chk_idle("flush_idle");

    // Per-bank lengths, consumed in ring order.
    do_fill(32'd3, 1'b1, -1);
    do_fill(32'd64, 1'b1, -1);
    do_fill(32'd7, 1'b1, -1);
    for (int s = 0; s < 3; s++) do_consume(1'b1, -1);

    // Ten-word segment, then concurrent fill and consume on different banks.
    do_fill(32'd10, 1'b1, -1);
    fork
      do_fill(32'd20, 1'b1, -1);
      do_consume(1'b1, -1);
    join
    do_consume(1'b1, -1);

    // Random lengths including 0 and oversize.
    for (int it = 0; it < 10; it++) begin
      if (lens.size() < NB && (lens.size() == 0 || $urandom_range(0, 1) == 1))
        do_fill(($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 70)), 1'b1, -1);
      else
        do_consume(1'b1, -1);
    end
    while (lens.size() != 0) do_consume(1'b1, -1);

    // Consume request on an empty ring stays pending until a fill completes.
    consume_req = 1'b1;
    tick();
    consume_req = 1'b0;
    cons_commit = 1'b1;
    tick();
    cons_commit = 1'b0;
    repeat (4) tick();
    for (int d = 0; d < 2; d++) begin
      chk("empty_cons_busy", d, 32'(consume_busy[d]), 0);
      chk("idle_commit_no_done", d, 32'(consume_done[d]), 0);
      chk_stall("cons_stall", d, csc[d]);
    end
    do_fill(32'd4, 1'b1, -1);
    for (int d = 0; d < 2; d++) chk("cons_grant_wait", d, 32'(consume_busy[d]), 0);
    tick();
    for (int d = 0; d < 2; d++) chk("cons_grant_after_fill", d, 32'(consume_busy[d]), 1);
    do_consume(1'b0, -1);

    // Flush in the middle of a fill.
    do_fill(32'd8, 1'b1, 3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    model_clear();
    chk_idle("flush_mid_fill");

    // Reset in the middle of a consume (after in-flight reads have returned).
    do_fill(32'd6, 1'b1, -1);
    do_consume(1'b1, 3);
    repeat (3) tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    model_clear();
    chk_idle("reset_mid_cons");
    tick();
    chk_idle("after_reset");

    // Ring works normally afterwards.
    do_fill(32'd9, 1'b1, -1);
    do_consume(1'b1, -1);
    repeat (4) tick();
    chk("rd_queue_drained", 0, 32'(q0.size()), 0);
    chk("rd_queue_drained", 1, 32'(q1.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_chk++;
    n_fail++;
    $display("FAIL watchdog: got no end of test expected finish before %0d cycles", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
